// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store memory master: width codes, FSM states
// and the request legality helpers used at accept time.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam int LSU_MEM_BYTES = 256;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        RESP = 2'd3
    } lsu_state_e;

    function automatic logic f3_legal(input logic store, input logic [2:0] f3);
        if (store)
            return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
               (f3 == F3_BU) || (f3 == F3_HU);
    endfunction

    // Only meaningful for legal codes: f3[1:0] is the log2 of the access size.
    function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] off);
        case (f3[1:0])
            2'b01:   return off[0];
            2'b10:   return off != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte/halfword lane handling: load extraction with sign/zero extension, and
// merging of sub-word store data into the previously read word.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_off,
    input  logic [31:0] i_word,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_load,
    output logic [31:0] o_merged
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        case (i_off)
            2'd0:    w_byte = i_word[7:0];
            2'd1:    w_byte = i_word[15:8];
            2'd2:    w_byte = i_word[23:16];
            default: w_byte = i_word[31:24];
        endcase
        w_half = i_off[1] ? i_word[31:16] : i_word[15:0];

        case (i_funct3)
            F3_B:    o_load = {{24{w_byte[7]}}, w_byte};
            F3_H:    o_load = {{16{w_half[15]}}, w_half};
            F3_W:    o_load = i_word;
            F3_BU:   o_load = {24'd0, w_byte};
            F3_HU:   o_load = {16'd0, w_half};
            default: o_load = 32'd0;
        endcase

        o_merged = i_word;
        case (i_funct3)
            F3_B: begin
                case (i_off)
                    2'd0:    o_merged[7:0]   = i_wdata[7:0];
                    2'd1:    o_merged[15:8]  = i_wdata[7:0];
                    2'd2:    o_merged[23:16] = i_wdata[7:0];
                    default: o_merged[31:24] = i_wdata[7:0];
                endcase
            end
            F3_H: begin
                if (i_off[1])
                    o_merged[31:16] = i_wdata[15:0];
                else
                    o_merged[15:0]  = i_wdata[15:0];
            end
            default: o_merged = i_wdata;
        endcase
    end

endmodule

// File: rtl/lsu_mem_master.sv
// Single-outstanding load/store initiator: drives a combinational-write data
// memory from flops, does read-modify-write for SB/SH, returns one response.
module lsu_mem_master
    import lsu_pkg::*;
#(
    parameter int MEM_AW    = 9,
    parameter int MEM_BYTES = LSU_MEM_BYTES
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_store,
    input  logic [2:0]        req_funct3,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic              mem_read,
    output logic              mem_write,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    lsu_state_e        r_state;
    logic              r_store;
    logic [2:0]        r_f3;
    logic [1:0]        r_off;
    logic [31:0]       r_wdata;
    logic [31:0]       r_word;
    logic              r_mem_read;
    logic              r_mem_write;
    logic [MEM_AW-1:0] r_mem_addr;
    logic [31:0]       r_mem_wdata;
    logic              r_err;

    logic              w_accept;
    logic              w_err;
    logic [31:0]       w_align_word;
    logic [31:0]       w_load;
    logic [31:0]       w_merged;

    assign w_accept = req_valid && (r_state == IDLE);
    assign w_err    = !f3_legal(req_store, req_funct3) ||
                      (req_addr >= 32'(MEM_BYTES)) ||
                      misaligned(req_funct3, req_addr[1:0]);

    // In RD the merge must see the live memory word; in RESP the load path
    // works from the captured copy.
    assign w_align_word = (r_state == RD) ? mem_rdata : r_word;

    lsu_lane_align u_align (
        .i_funct3 (r_f3),
        .i_off    (r_off),
        .i_word   (w_align_word),
        .i_wdata  (r_wdata),
        .o_load   (w_load),
        .o_merged (w_merged)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_err       <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_mem_addr <= {req_addr[MEM_AW-1:2], 2'b00};
                        if (w_err) begin
                            r_err   <= 1'b1;
                            r_state <= RESP;
                        end else if (req_store && (req_funct3 == F3_W)) begin
                            r_mem_write <= 1'b1;
                            r_mem_wdata <= req_wdata;
                            r_state     <= WR;
                        end else begin
                            r_mem_read <= 1'b1;
                            r_state    <= RD;
                        end
                    end
                end
                RD: begin
                    r_mem_read <= 1'b0;
                    if (r_store) begin
                        r_mem_write <= 1'b1;
                        r_mem_wdata <= w_merged;
                        r_state     <= WR;
                    end else begin
                        r_state <= RESP;
                    end
                end
                WR: begin
                    r_mem_write <= 1'b0;
                    r_mem_wdata <= '0;
                    r_state     <= RESP;
                end
                default: begin
                    if (resp_ready) begin
                        r_err      <= 1'b0;
                        r_mem_addr <= '0;
                        r_state    <= IDLE;
                    end
                end
            endcase
        end
    end

    // Request payload and the read word carry no reset; they are only
    // consumed in states that are reachable after a fresh accept.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_store <= req_store;
            r_f3    <= req_funct3;
            r_off   <= req_addr[1:0];
            r_wdata <= req_wdata;
        end
        if (r_state == RD)
            r_word <= mem_rdata;
    end

    assign req_ready  = (r_state == IDLE);
    assign resp_valid = (r_state == RESP);
    assign resp_err   = r_err;
    assign resp_rdata = (r_state == RESP && !r_store && !r_err) ? w_load : 32'd0;
    assign mem_read   = r_mem_read;
    assign mem_write  = r_mem_write;
    assign mem_addr   = r_mem_addr;
    assign mem_wdata  = r_mem_wdata;

endmodule

// File: doc/lsu_mem_master.md
Name: lsu_mem_master

Overview:
- Load/store initiator that sits between the execute stage and the data memory.
- Accepts one load or store request at a time from the core and drives the memory's mem_read / mem_write / address / write-data interface.
- Performs byte and halfword extraction with sign or zero extension for loads.
- Performs read-modify-write for sub-word stores.
- Returns a single response (load data or error) to the core through a valid/ready handshake.

Parameters:
- MEM_AW, 9, width of the memory byte address. The memory indexes words with address bits [7:2].
- MEM_BYTES, 256, addressable bytes. Any access at or above this address is an error.

Ports:
- clk  in  1  system clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  core presents a request
- req_ready  out  1  high only in IDLE; a request is accepted when req_valid and req_ready are both high
- req_store  in  1  1 = store, 0 = load
- req_funct3  in  3  RISC-V width code: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores use 000 SB, 001 SH, 010 SW
- req_addr  in  32  byte address
- req_wdata  in  32  store data (low bits used for SB/SH)
- resp_valid  out  1  response available; held until resp_ready
- resp_ready  in  1  core consumes the response
- resp_rdata  out  32  extended load result; 0 for stores and errors
- resp_err  out  1  misaligned, out-of-range, or illegal funct3
- mem_read  out  1  memory read strobe
- mem_write  out  1  memory write strobe
- mem_addr  out  MEM_AW  word-aligned address; bits [1:0] are always 0
- mem_wdata  out  32  full word written to memory
- mem_rdata  in  32  memory read data; combinational, valid in the same cycle as mem_read

Behaviour:
- Reset: every output is 0 except req_ready, which is 1. State goes to IDLE. A reset mid-transaction abandons it; no write is issued after reset.
- The memory writes combinationally, so all memory-side outputs come directly from flops.
  - mem_addr and mem_wdata are stable for the whole cycle mem_write is high.
  - mem_addr is captured at accept and held until the return to IDLE.
- States: IDLE, RD, WR, RESP.
- IDLE, on accept:
  - Latch req_store, req_funct3, req_addr[1:0], req_wdata.
  - Set mem_addr = {req_addr[MEM_AW-1:2], 2'b00}.
- Error check at accept: addr >= MEM_BYTES; halfword with addr[0] = 1; word with addr[1:0] != 0; or an undefined funct3 (loads 011/11x, stores other than 000/001/010).
  - On error: go to RESP with resp_err = 1 and resp_rdata = 0. No memory strobe is ever raised.
- Load: IDLE → RD → RESP.
  - RD: mem_read = 1; capture mem_rdata into the internal word register at the end of the cycle.
  - RESP: resp_rdata is the selected lane from addr[1:0], sign-extended for LB/LH or zero-extended for LBU/LHU; the full word for LW.
  - Latency: resp_valid is high 2 cycles after accept.
- SW: IDLE → WR → RESP.
  - WR: mem_write = 1 for exactly one cycle, with mem_wdata = req_wdata.
  - Latency: 2 cycles.
- SB/SH: IDLE → RD → WR → RESP.
  - RD reads the old word.
  - WR writes the old word with the addressed byte lane (SB: req_wdata[7:0]) or halfword lane (SH: req_wdata[15:0]) replaced.
  - Latency: 3 cycles.
- Strobes: mem_read and mem_write are never high together. mem_wdata is 0 outside WR.
- RESP:
  - resp_valid = 1; resp_rdata and resp_err are held stable while resp_ready = 0.
  - When resp_ready = 1, go to IDLE the next cycle, clear the resp_* outputs and raise req_ready.
  - No new request is accepted in the same cycle that the response is consumed.
- req_valid outside IDLE is ignored; request inputs need not stay stable after accept.

Decomposition:
- Shared package lsu_pkg:
  - funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU).
  - State enum (IDLE, RD, WR, RESP).
  - MEM_BYTES default.
- Natural sub-module lsu_lane_align, purely combinational:
  - Load lane extraction and extension.
  - Store byte/halfword merge into the old word.
- Shared by the RESP and WR datapaths.

Test Plan:
- Memory model holds word 1 (addr 0x4) = 0x8000_00F0. LB at 0x4 → resp_rdata = 0xFFFF_FFF0. LBU at 0x4 → 0x0000_00F0. LH at 0x6 → 0xFFFF_8000. LW at 0x4 → 0x8000_00F0. Each resp_valid arrives 2 cycles after accept.
- SW 0xDEAD_BEEF at 0x8 → exactly one mem_write cycle with mem_addr = 0x008 and mem_wdata = 0xDEAD_BEEF. resp_valid 2 cycles after accept with resp_err = 0.
- Word at 0xC = 0x1122_3344. SB 0xAA at 0xE → sequence mem_read, then mem_write with wdata 0x11AA_3344; latency 3. SH 0x5566 at 0xC then gives 0x11AA_5566.
- LW at 0x5, SH at 0x3, LB at 0x100, LW with funct3 = 011 → each gives resp_err = 1 one cycle after accept, resp_rdata = 0, and no mem_read/mem_write.
- Hold resp_ready = 0 for 4 cycles → resp_valid, resp_rdata and req_ready = 0 stay stable; toggling req_valid is ignored. Then resp_ready = 1 → IDLE and req_ready = 1 the next cycle.
- Assert reset during the RD state of an SB → no mem_write ever occurs; next cycle all outputs are 0 and req_ready = 1.
